// File: rtl/layer_tile_scheduler.sv
// ----------------------------------------------------------------------------
// layer_tile_scheduler
//
// Per-layer sequencer sitting between the main controller and the systolic
// PE array. A start_layer pulse latches the layer configuration. One cycle is
// then spent deriving the output-plane size, the per-tile OFM/weight strides
// and the number of filter groups. The filters are split into groups of
// SYSTOLIC_SIZE, and each group is issued as one start_tile / done_tile
// handshake. After the last group completes, done_layer is pulsed back to the
// controller.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_layer           one-cycle layer start pulse (ignored while busy)
//   ifm_size .. upsample_mode, start_write_addr, start_read_addr
//                         layer configuration, sampled on start_layer
//   done_tile             one-cycle tile completion pulse from the datapath
//   start_tile            one-cycle tile start pulse
//   tile_num_filter       filters in the current tile (1..SYSTOLIC_SIZE)
//   tile_write_addr       OFM write base for the current tile
//   tile_read_addr        IFM read base (latched start_read_addr)
//   tile_weight_offset    weight offset for the current tile
//   busy                  high from CALC through DONE
//   done_layer            one-cycle layer completion pulse
// ----------------------------------------------------------------------------
module layer_tile_scheduler #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_RAM_SIZE  = 2378675,
    parameter int WGT_ADDR_W    = 23,
    localparam int ADDR_W       = $clog2(OFM_RAM_SIZE),
    localparam int TNF_W        = $clog2(SYSTOLIC_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_layer,
    input  logic [8:0]            ifm_size,
    input  logic [10:0]           ifm_channel,
    input  logic [1:0]            kernel_size,
    input  logic [10:0]           num_filter,
    input  logic                  maxpool_mode,
    input  logic [1:0]            maxpool_stride,
    input  logic                  upsample_mode,
    input  logic [ADDR_W-1:0]     start_write_addr,
    input  logic [ADDR_W-1:0]     start_read_addr,
    input  logic                  done_tile,
    output logic                  start_tile,
    output logic [TNF_W-1:0]      tile_num_filter,
    output logic [ADDR_W-1:0]     tile_write_addr,
    output logic [ADDR_W-1:0]     tile_read_addr,
    output logic [WGT_ADDR_W-1:0] tile_weight_offset,
    output logic                  busy,
    output logic                  done_layer
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state;

    // Latched layer configuration
    logic [8:0]            cfg_ifm_size;
    logic [10:0]           cfg_ifm_channel;
    logic [1:0]            cfg_kernel_size;
    logic [10:0]           cfg_num_filter;
    logic                  cfg_maxpool_mode;
    logic [1:0]            cfg_maxpool_stride;
    logic                  cfg_upsample_mode;
    logic [ADDR_W-1:0]     cfg_start_write_addr;

    // Per-layer derived values and group bookkeeping
    logic [ADDR_W-1:0]     wr_step;
    logic [WGT_ADDR_W-1:0] wgt_step;
    logic [11:0]           num_groups;
    logic [11:0]           group;
    logic [10:0]           remaining;
    logic [10:0]           remaining_next;
    // Set on a non-final done_tile; the stride update happens in the
    // following cycle so the next start_tile lands two cycles after done_tile.
    logic                  advance_q;

    // Combinational derivation from the latched configuration
    logic [9:0]            conv_out;
    logic [10:0]           ofm;
    logic [ADDR_W-1:0]     ofm_a;
    logic [ADDR_W-1:0]     wr_step_c;
    logic [WGT_ADDR_W-1:0] wgt_step_c;
    logic [11:0]           num_groups_c;

    function automatic logic [TNF_W-1:0] clamp_tile(input logic [10:0] rem);
        if (rem >= 11'(SYSTOLIC_SIZE))
            return TNF_W'(SYSTOLIC_SIZE);
        return TNF_W'(rem);
    endfunction

    always_comb begin
        conv_out = 10'(cfg_ifm_size) - 10'(cfg_kernel_size) + 10'd1;
        ofm      = {1'b0, conv_out};
        // Pooling takes precedence over upsampling if both are set.
        if (cfg_maxpool_mode && (cfg_maxpool_stride == 2'd2))
            ofm = 11'(conv_out >> 1);
        else if (cfg_upsample_mode)
            ofm = {conv_out, 1'b0};
        ofm_a        = ADDR_W'(ofm);
        wr_step_c    = ofm_a * ofm_a * ADDR_W'(SYSTOLIC_SIZE);
        wgt_step_c   = WGT_ADDR_W'(cfg_ifm_channel) * WGT_ADDR_W'(cfg_kernel_size)
                     * WGT_ADDR_W'(cfg_kernel_size) * WGT_ADDR_W'(SYSTOLIC_SIZE);
        num_groups_c = ({1'b0, cfg_num_filter} + 12'(SYSTOLIC_SIZE - 1))
                     / 12'(SYSTOLIC_SIZE);
        remaining_next = remaining - 11'(SYSTOLIC_SIZE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            cfg_ifm_size         <= '0;
            cfg_ifm_channel      <= '0;
            cfg_kernel_size      <= '0;
            cfg_num_filter       <= '0;
            cfg_maxpool_mode     <= 1'b0;
            cfg_maxpool_stride   <= '0;
            cfg_upsample_mode    <= 1'b0;
            cfg_start_write_addr <= '0;
            wr_step              <= '0;
            wgt_step             <= '0;
            num_groups           <= '0;
            group                <= '0;
            remaining            <= '0;
            advance_q            <= 1'b0;
            start_tile           <= 1'b0;
            tile_num_filter      <= '0;
            tile_write_addr      <= '0;
            tile_read_addr       <= '0;
            tile_weight_offset   <= '0;
            busy                 <= 1'b0;
            done_layer           <= 1'b0;
        end else begin
            start_tile <= 1'b0;
            done_layer <= 1'b0;
            case (state)
                S_IDLE: begin
                    // done_tile is meaningless here and is dropped.
                    if (start_layer) begin
                        cfg_ifm_size         <= ifm_size;
                        cfg_ifm_channel      <= ifm_channel;
                        cfg_kernel_size      <= kernel_size;
                        cfg_num_filter       <= num_filter;
                        cfg_maxpool_mode     <= maxpool_mode;
                        cfg_maxpool_stride   <= maxpool_stride;
                        cfg_upsample_mode    <= upsample_mode;
                        cfg_start_write_addr <= start_write_addr;
                        tile_read_addr       <= start_read_addr;
                        busy                 <= 1'b1;
                        state                <= S_CALC;
                    end
                end
                S_CALC: begin
                    wr_step            <= wr_step_c;
                    wgt_step           <= wgt_step_c;
                    num_groups         <= num_groups_c;
                    group              <= '0;
                    remaining          <= cfg_num_filter;
                    tile_write_addr    <= cfg_start_write_addr;
                    tile_weight_offset <= '0;
                    advance_q          <= 1'b0;
                    if (cfg_num_filter == 11'd0) begin
                        done_layer <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        start_tile      <= 1'b1;
                        tile_num_filter <= clamp_tile(cfg_num_filter);
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (advance_q) begin
                        // Strides are accumulated rather than multiplied by group.
                        advance_q          <= 1'b0;
                        group              <= group + 12'd1;
                        tile_write_addr    <= tile_write_addr + wr_step;
                        tile_weight_offset <= tile_weight_offset + wgt_step;
                        remaining          <= remaining_next;
                        tile_num_filter    <= clamp_tile(remaining_next);
                        start_tile         <= 1'b1;
                        state              <= S_ISSUE;
                    end else if (done_tile) begin
                        if (group == num_groups - 12'd1) begin
                            done_layer <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            advance_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_tile_scheduler.sv
module tb_layer_tile_scheduler;

    localparam int ADDR_W = 22;
    localparam int WGT_W  = 23;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_layer;
    logic [8:0]        ifm_size;
    logic [10:0]       ifm_channel;
    logic [1:0]        kernel_size;
    logic [10:0]       num_filter;
    logic              maxpool_mode;
    logic [1:0]        maxpool_stride;
    logic              upsample_mode;
    logic [ADDR_W-1:0] start_write_addr;
    logic [ADDR_W-1:0] start_read_addr;
    logic              done_tile;
    logic              start_tile;
    logic [4:0]        tile_num_filter;
    logic [ADDR_W-1:0] tile_write_addr;
    logic [ADDR_W-1:0] tile_read_addr;
    logic [WGT_W-1:0]  tile_weight_offset;
    logic              busy;
    logic              done_layer;

    layer_tile_scheduler dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_layer        (start_layer),
        .ifm_size           (ifm_size),
        .ifm_channel        (ifm_channel),
        .kernel_size        (kernel_size),
        .num_filter         (num_filter),
        .maxpool_mode       (maxpool_mode),
        .maxpool_stride     (maxpool_stride),
        .upsample_mode      (upsample_mode),
        .start_write_addr   (start_write_addr),
        .start_read_addr    (start_read_addr),
        .done_tile          (done_tile),
        .start_tile         (start_tile),
        .tile_num_filter    (tile_num_filter),
        .tile_write_addr    (tile_write_addr),
        .tile_read_addr     (tile_read_addr),
        .tile_weight_offset (tile_weight_offset),
        .busy               (busy),
        .done_layer         (done_layer)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint nf;
        longint wr;
        longint wgt;
        longint rd;
    } tile_t;

    tile_t exp_q[$];
    int    vectors    = 0;
    int    miscompare = 0;
    int    tiles_seen = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompare++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every start_tile pops the next expected tile.
    always @(negedge clk) begin
        if (rst_n && start_tile) begin
            tile_t e;
            tiles_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_start_tile", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("tile_num_filter", longint'(tile_num_filter), e.nf);
                check("tile_write_addr", longint'(tile_write_addr), e.wr);
                check("tile_weight_offset", longint'(tile_weight_offset), e.wgt);
                check("tile_read_addr", longint'(tile_read_addr), e.rd);
            end
        end
    end

    // Counts falling edges until the selected output is seen high (0:start_tile, 1:done_layer).
    task automatic wait_sig(input int which, input string tag, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((which == 0 && start_tile) || (which == 1 && done_layer)) begin
                n = i;
                return;
            end
        end
        check({tag, "_timeout"}, 0, 1);
        n = -1;
    endtask

    task automatic pulse_start(input bit with_done);
        @(posedge clk); #1;
        start_layer = 1'b1;
        done_tile   = with_done;
        @(posedge clk); #1;
        start_layer = 1'b0;
        done_tile   = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        done_tile = 1'b1;
        @(posedge clk); #1;
        done_tile = 1'b0;
    endtask

    task automatic run_layer(input int ifm, input int ch, input int k, input int nf,
                             input int mp, input int mps, input int up,
                             input longint wr, input longint rd,
                             input int abort_tile, input bit inject, input bit with_done);
        longint conv, ofm, wrs, wgs;
        int     ng, n;
        conv = ifm - k + 1;
        if (mp != 0 && mps == 2) ofm = conv / 2;
        else if (up != 0)        ofm = 2 * conv;
        else                     ofm = conv;
        wrs = ofm * ofm * 16;
        wgs = 16 * ch * k * k;
        ng  = (nf + 15) / 16;
        for (int g = 0; g < ng; g++) begin
            tile_t e;
            e.nf  = (nf - 16 * g > 16) ? 16 : nf - 16 * g;
            e.wr  = (wr + g * wrs) % (64'd1 << ADDR_W);
            e.wgt = (g * wgs) % (64'd1 << WGT_W);
            e.rd  = rd;
            exp_q.push_back(e);
        end
        tiles_seen       = 0;
        ifm_size         = 9'(ifm);
        ifm_channel      = 11'(ch);
        kernel_size      = 2'(k);
        num_filter       = 11'(nf);
        maxpool_mode     = 1'(mp);
        maxpool_stride   = 2'(mps);
        upsample_mode    = 1'(up);
        start_write_addr = ADDR_W'(wr);
        start_read_addr  = ADDR_W'(rd);
        pulse_start(with_done);

        if (ng == 0) begin
            wait_sig(1, "nf0_done", n);
            check("nf0_done_latency", n, 2);
            check("nf0_tiles", tiles_seen, 0);
        end
        for (int g = 0; g < ng; g++) begin
            wait_sig(0, $sformatf("tile%0d", g), n);
            check($sformatf("tile%0d_latency", g), n, 2);
            check($sformatf("tile%0d_busy", g), busy, 1);
            if (g == abort_tile) begin
                @(posedge clk); #1;
                rst_n = 1'b0;
                #1;
                check("abort_start_tile", start_tile, 0);
                check("abort_busy", busy, 0);
                check("abort_write_addr", longint'(tile_write_addr), 0);
                check("abort_weight", longint'(tile_weight_offset), 0);
                check("abort_num_filter", longint'(tile_num_filter), 0);
                check("abort_read_addr", longint'(tile_read_addr), 0);
                exp_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("abort_no_done_layer", done_layer, 0);
                end
                return;
            end
            if (inject && g == 1) begin
                // done_tile while in ISSUE, then a start_layer with a different config in WAIT.
                done_tile = 1'b1;
                @(posedge clk); #1;
                done_tile   = 1'b0;
                num_filter  = 11'd16;
                ifm_channel = 11'd3;
                pulse_start(1'b0);
                check("inject_busy", busy, 1);
            end
            repeat (g % 3) @(posedge clk);
            pulse_done();
        end
        if (ng > 0) begin
            wait_sig(1, "done_layer", n);
            check("done_layer_latency", n, 1);
            @(negedge clk);
            check("done_layer_width", done_layer, 0);
            check("busy_after_layer", busy, 0);
            check("tile_count", tiles_seen, ng);
        end
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_layer = 1'b0; done_tile = 1'b0;
        ifm_size = '0; ifm_channel = '0; kernel_size = '0; num_filter = '0;
        maxpool_mode = 1'b0; maxpool_stride = '0; upsample_mode = 1'b0;
        start_write_addr = '0; start_read_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start_tile", start_tile, 0);
        check("rst_busy", busy, 0);
        check("rst_done_layer", done_layer, 0);
        check("rst_write_addr", longint'(tile_write_addr), 0);
        check("rst_num_filter", longint'(tile_num_filter), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // done_tile in IDLE must not start anything.
        pulse_done();
        repeat (3) @(negedge clk);
        check("idle_done_busy", busy, 0);
        check("idle_done_tiles", tiles_seen, 0);

        // Single tile, pooled 54x54 3x3
        run_layer(54, 16, 3, 16, 1, 2, 0, 0, 0, -1, 1'b0, 1'b0);
        // 16 tiles, partial last, with ignored start/done injections
        run_layer(13, 512, 1, 255, 0, 1, 0, 1730560, 1644032, -1, 1'b1, 1'b0);
        // Upsample; start and done_tile in the same IDLE cycle
        run_layer(13, 256, 1, 128, 0, 1, 1, 100000, 5000, -1, 1'b0, 1'b1);
        // Maxpool with stride 1 keeps conv_out
        run_layer(20, 7, 3, 33, 1, 1, 0, 4194000, 77, -1, 1'b0, 1'b0);
        // No filters
        run_layer(13, 16, 1, 0, 0, 1, 0, 123, 456, -1, 1'b0, 1'b0);
        // Reset in WAIT of tile 3, then restart from tile 0
        run_layer(13, 512, 1, 255, 0, 1, 0, 1730560, 1644032, 3, 1'b0, 1'b0);
        run_layer(13, 512, 1, 100, 0, 1, 0, 2000, 9, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/layer_tile_scheduler.md
Name: layer_tile_scheduler

Overview:
Per-layer sequencer between the main controller and the systolic PE array. On start_layer it latches the current layer configuration and computes the output-plane size and per-tile address strides. It then splits num_filter into filter groups of SYSTOLIC_SIZE and issues one start_tile/done_tile handshake per group, supplying the OFM write address and weight offset for each group. After the last group completes it pulses done_layer back to the main controller.

Parameters:
SYSTOLIC_SIZE, 16, filters processed per tile (PE array columns)
OFM_RAM_SIZE, 2378675, OFM RAM depth; ADDR_W = $clog2(OFM_RAM_SIZE) = 22
WGT_ADDR_W, 23, width of the weight offset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_layer  in  1  one-cycle start pulse from the main controller
ifm_size  in  9  input feature-map side length
ifm_channel  in  11  input channels
kernel_size  in  2  kernel side length (1 or 3)
num_filter  in  11  number of output filters
maxpool_mode  in  1  maxpool enable
maxpool_stride  in  2  maxpool stride (1 or 2)
upsample_mode  in  1  2x upsample enable
start_write_addr  in  ADDR_W  OFM base address for the layer
start_read_addr  in  ADDR_W  IFM base address for the layer
done_tile  in  1  one-cycle pulse from the datapath when a tile completes
start_tile  out  1  one-cycle tile start pulse
tile_num_filter  out  $clog2(SYSTOLIC_SIZE+1)  filters in the current tile
tile_write_addr  out  ADDR_W  OFM write base for the current tile
tile_read_addr  out  ADDR_W  IFM read base (equals the latched start_read_addr)
tile_weight_offset  out  WGT_ADDR_W  weight offset for the current tile
busy  out  1  high from CALC through DONE
done_layer  out  1  one-cycle layer completion pulse

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. An rst_n assertion mid-layer aborts immediately with no done_layer pulse.
- All outputs are registered.
- States: IDLE, CALC, ISSUE, WAIT, DONE.
- IDLE:
  - start_layer=1 latches every config input and moves to CALC.
  - done_tile is ignored.
- CALC (1 cycle), computed from the latched values:
  - conv_out = ifm_size - kernel_size + 1.
  - ofm = conv_out/2 (floor) if maxpool_mode and stride 2; 2*conv_out if upsample_mode; otherwise conv_out.
  - wr_step = ofm*ofm*SYSTOLIC_SIZE.
  - wgt_step = SYSTOLIC_SIZE*ifm_channel*kernel_size^2.
  - num_groups = ceil(num_filter/SYSTOLIC_SIZE).
  - Loads group=0, tile_write_addr=start_write_addr, tile_weight_offset=0, remaining=num_filter.
  - Next state: ISSUE, or DONE if num_filter==0.
- ISSUE (1 cycle):
  - start_tile=1.
  - tile_num_filter = min(remaining, SYSTOLIC_SIZE).
  - Moves to WAIT.
  - A done_tile that arrives during ISSUE is ignored.
- WAIT:
  - tile_* outputs are held stable.
  - On done_tile with group==num_groups-1: go to DONE.
  - On done_tile otherwise: group+1, tile_write_addr += wr_step, tile_weight_offset += wgt_step, remaining -= SYSTOLIC_SIZE, then go to ISSUE.
  - These are incremental adds; no per-tile multiply.
- DONE (1 cycle): done_layer=1, busy=0 on exit, return to IDLE.
- Latency: start_layer at cycle N gives start_tile at N+2. done_tile at cycle M gives the next start_tile at M+2, or done_layer at M+1 after the last tile.
- start_layer while busy: ignored; the latched config does not change.
- Address arithmetic is modulo 2^ADDR_W / 2^WGT_ADDR_W. There is no overflow flag; keeping addresses in range is the config's responsibility.
- start_layer and done_tile in the same IDLE cycle: start is accepted and done_tile is dropped.

Test Plan:
- Single tile: ifm 54, ch 16, k 3, nf 16, pool s2, wr 0, rd 0.
  - One start_tile at start+2 with tile_num_filter=16, write 0, weight 0.
  - done_tile → done_layer the next cycle.
- Multi-tile with partial last tile: ifm 13, ch 512, k 1, nf 255, no pool, wr 1730560, rd 1644032.
  - 16 tiles; tile 1 write 1733264, weight 8192.
  - Tile 15 write 1771120, weight 122880, tile_num_filter=15.
  - tile_read_addr=1644032 throughout.
- Upsample: ifm 13, ch 256, k 1, nf 128, upsample.
  - ofm 26, wr_step 10816, 8 tiles, last write = start + 7*10816.
- num_filter=0: done_layer at start+2 with no start_tile.
- start_layer pulsed during WAIT and done_tile pulsed during ISSUE: both are ignored and the tile count is unchanged.
- rst_n asserted in WAIT of tile 3: all outputs go to 0 immediately; a subsequent start_layer restarts from tile 0.
